// File: rtl/m_mem_arbiter_pkg.sv
// m_mem_arbiter_pkg: shared widths, D-streak limit and response tag encoding
package m_mem_arbiter_pkg;
    localparam int ADDR_W_DEF = 12;
    localparam int DATA_W_DEF = 32;
    localparam int MAX_D_STREAK_DEF = 4;
    typedef enum logic [1:0] {TAG_NONE = 2'd0, TAG_I = 2'd1, TAG_D = 2'd2} tag_e;
endpackage

// File: rtl/m_mem_arbiter_if.sv
// m_mem_arbiter_if: instruction port, data port and memory-side signals of the arbiter
interface m_mem_arbiter_if
    import m_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    logic              w_i_req;
    logic [ADDR_W-1:0] w_i_addr;
    logic              w_i_flush;
    logic              w_i_gnt;
    logic              w_i_rvalid;
    logic [DATA_W-1:0] w_i_rdata;
    logic              w_d_req;
    logic              w_d_we;
    logic [ADDR_W-1:0] w_d_addr;
    logic [DATA_W-1:0] w_d_wdata;
    logic              w_d_gnt;
    logic              w_d_rvalid;
    logic [DATA_W-1:0] w_d_rdata;
    logic [ADDR_W-1:0] w_m_addr;
    logic              w_m_we;
    logic [DATA_W-1:0] w_m_wdata;
    logic [DATA_W-1:0] w_m_rdata;

    modport slave (
        input  w_i_req, w_i_addr, w_i_flush, w_d_req, w_d_we, w_d_addr, w_d_wdata, w_m_rdata,
        output w_i_gnt, w_i_rvalid, w_i_rdata, w_d_gnt, w_d_rvalid, w_d_rdata,
               w_m_addr, w_m_we, w_m_wdata
    );
    modport master (
        output w_i_req, w_i_addr, w_i_flush, w_d_req, w_d_we, w_d_addr, w_d_wdata, w_m_rdata,
        input  w_i_gnt, w_i_rvalid, w_i_rdata, w_d_gnt, w_d_rvalid, w_d_rdata,
               w_m_addr, w_m_we, w_m_wdata
    );
endinterface

// File: rtl/m_mem_arbiter_pick.sv
// m_arb_pick: D-over-I priority with a contended-D streak counter that forces an I grant
module m_arb_pick
    import m_mem_arbiter_pkg::*;
#(
    parameter int MAX_D_STREAK = MAX_D_STREAK_DEF
) (
    input  logic w_clk,
    input  logic w_rst_n,
    input  logic w_i_req,
    input  logic w_d_req,
    output logic w_i_gnt,
    output logic w_d_gnt
);
    localparam int SW = $clog2(MAX_D_STREAK + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);

    logic [SW-1:0] r_streak;
    logic          w_i_force;

    always_comb begin
        w_i_force = w_i_req & (r_streak == STREAK_MAX);
        w_d_gnt = w_rst_n & w_d_req & ~w_i_force;
        w_i_gnt = w_rst_n & w_i_req & ~w_d_gnt;
    end

    // Only D grants that actually kept I waiting count towards the streak
    always_ff @(posedge w_clk or negedge w_rst_n)
        if (!w_rst_n) r_streak <= '0;
        else if (w_i_gnt || !w_i_req) r_streak <= '0;
        else if (w_d_gnt && r_streak != STREAK_MAX) r_streak <= r_streak + 1'b1;
endmodule

// File: rtl/m_mem_arbiter.sv
// m_mem_arbiter: shares one 1-cycle-latency memory between instruction and data ports,
// tagging each grant so the next-cycle read data is routed to the right port.
module m_mem_arbiter
    import m_mem_arbiter_pkg::*;
#(
    parameter int MAX_D_STREAK = MAX_D_STREAK_DEF
) (
    input logic            w_clk,
    input logic            w_rst_n,
    m_mem_arbiter_if.slave bus
);
    localparam int DW = $bits(bus.w_m_rdata);

    tag_e          r_tag;
    logic [DW-1:0] r_i_hold;
    logic [DW-1:0] r_d_hold;

    m_arb_pick #(.MAX_D_STREAK(MAX_D_STREAK)) u_pick (
        .w_clk   (w_clk),
        .w_rst_n (w_rst_n),
        .w_i_req (bus.w_i_req),
        .w_d_req (bus.w_d_req),
        .w_i_gnt (bus.w_i_gnt),
        .w_d_gnt (bus.w_d_gnt)
    );

    always_comb begin
        bus.w_m_addr = bus.w_i_gnt ? bus.w_i_addr : bus.w_d_addr;
        bus.w_m_we = bus.w_d_gnt & bus.w_d_we;
        bus.w_m_wdata = bus.w_d_wdata;
        bus.w_i_rvalid = (r_tag == TAG_I) & ~bus.w_i_flush;
        bus.w_d_rvalid = r_tag == TAG_D;
        bus.w_i_rdata = bus.w_i_rvalid ? bus.w_m_rdata : r_i_hold;
        bus.w_d_rdata = bus.w_d_rvalid ? bus.w_m_rdata : r_d_hold;
    end

    // A flushed I response never reaches the holding register
    always_ff @(posedge w_clk or negedge w_rst_n)
        if (!w_rst_n) begin
            r_tag <= TAG_NONE;
            r_i_hold <= '0;
            r_d_hold <= '0;
        end else begin
            r_tag <= bus.w_i_gnt ? TAG_I : (bus.w_d_gnt & ~bus.w_d_we) ? TAG_D : TAG_NONE;
            if (bus.w_i_rvalid) r_i_hold <= bus.w_m_rdata;
            if (bus.w_d_rvalid) r_d_hold <= bus.w_m_rdata;
        end
endmodule

// File: tb/tb_m_mem_arbiter.sv
// tb_m_mem_arbiter: directed stimulus with grant checks; read responses go through
// per-port expectation queues drained by an independent monitor.
module tb_m_mem_arbiter;
    logic w_clk = 1'b0;
    logic w_rst_n = 1'b0;
    int   errs = 0;
    int   checks = 0;
    int   cyc_n = 0;

    m_mem_arbiter_if #(.ADDR_W(12), .DATA_W(32)) bus ();

    m_mem_arbiter #(.MAX_D_STREAK(4)) dut (
        .w_clk   (w_clk),
        .w_rst_n (w_rst_n),
        .bus     (bus)
    );

    always #5 w_clk = ~w_clk;

    logic [31:0] mem [4096];
    initial for (int k = 0; k < 4096; k++) mem[k] = 32'(k + 'h100);

    always @(posedge w_clk) begin
        if (bus.w_m_we) mem[bus.w_m_addr] <= bus.w_m_wdata;
        bus.w_m_rdata <= mem[bus.w_m_addr];
    end

    logic [31:0] q_i [$];
    logic [31:0] q_d [$];
    logic [31:0] h_i = '0;
    logic [31:0] h_d = '0;
    logic [31:0] e_mon;

    always @(negedge w_clk) begin
        if (!w_rst_n) begin
            checks++;
            if (bus.w_i_rvalid || bus.w_d_rvalid || bus.w_i_rdata != 0 || bus.w_d_rdata != 0) begin
                errs++;
                $display("FAIL reset_out cycle=%0d got iv=%b dv=%b ird=%h drd=%h want all 0",
                         cyc_n, bus.w_i_rvalid, bus.w_d_rvalid, bus.w_i_rdata, bus.w_d_rdata);
            end
            h_i = '0;
            h_d = '0;
        end else begin
            checks++;
            if (bus.w_i_rvalid) begin
                if (q_i.size() == 0) begin
                    errs++;
                    $display("FAIL i_unexpected cycle=%0d got rvalid data=%h want no rvalid", cyc_n, bus.w_i_rdata);
                end else begin
                    e_mon = q_i.pop_front();
                    h_i = e_mon;
                    if (bus.w_i_rdata !== e_mon) begin
                        errs++;
                        $display("FAIL i_rdata cycle=%0d got %h want %h", cyc_n, bus.w_i_rdata, e_mon);
                    end
                end
            end else if (bus.w_i_rdata !== h_i) begin
                errs++;
                $display("FAIL i_hold cycle=%0d got %h want %h", cyc_n, bus.w_i_rdata, h_i);
            end
            checks++;
            if (bus.w_d_rvalid) begin
                if (q_d.size() == 0) begin
                    errs++;
                    $display("FAIL d_unexpected cycle=%0d got rvalid data=%h want no rvalid", cyc_n, bus.w_d_rdata);
                end else begin
                    e_mon = q_d.pop_front();
                    h_d = e_mon;
                    if (bus.w_d_rdata !== e_mon) begin
                        errs++;
                        $display("FAIL d_rdata cycle=%0d got %h want %h", cyc_n, bus.w_d_rdata, e_mon);
                    end
                end
            end else if (bus.w_d_rdata !== h_d) begin
                errs++;
                $display("FAIL d_hold cycle=%0d got %h want %h", cyc_n, bus.w_d_rdata, h_d);
            end
        end
    end

    // One cycle: drive inputs, check grants/memory drive, queue expected read responses
    task automatic cyc(input int rn, input int ir, input int ia, input int fl,
                       input int dr, input int dw, input int da, input logic [31:0] dd,
                       input int eig, input int edg,
                       input int pi, input logic [31:0] ei, input int pd, input logic [31:0] ed);
        logic [11:0] ea;
        @(posedge w_clk);
        #1;
        cyc_n++;
        w_rst_n = rn != 0;
        bus.w_i_req = ir != 0;
        bus.w_i_addr = 12'(ia);
        bus.w_i_flush = fl != 0;
        bus.w_d_req = dr != 0;
        bus.w_d_we = dw != 0;
        bus.w_d_addr = 12'(da);
        bus.w_d_wdata = dd;
        ea = eig != 0 ? 12'(ia) : 12'(da);
        @(negedge w_clk);
        checks++;
        if (bus.w_i_gnt !== (eig != 0) || bus.w_d_gnt !== (edg != 0) ||
            bus.w_m_we !== (edg != 0 && dw != 0) || bus.w_m_addr !== ea) begin
            errs++;
            $display("FAIL grant cycle=%0d got ig=%b dg=%b we=%b addr=%h want ig=%0d dg=%0d we=%0d addr=%h",
                     cyc_n, bus.w_i_gnt, bus.w_d_gnt, bus.w_m_we, bus.w_m_addr,
                     eig, edg, (edg != 0 && dw != 0), ea);
        end
        #1;
        if (pi != 0) q_i.push_back(ei);
        if (pd != 0) q_d.push_back(ed);
    endtask

    initial begin
        bus.w_i_req = 1'b0;
        bus.w_i_addr = '0;
        bus.w_i_flush = 1'b0;
        bus.w_d_req = 1'b0;
        bus.w_d_we = 1'b0;
        bus.w_d_addr = '0;
        bus.w_d_wdata = '0;
        // rn ir ia fl  dr dw da dd  eig edg  pi ei  pd ed
        cyc(0, 1, 0, 0, 1, 1, 5, 32'h1, 0, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 1, 1, 5, 32'h1, 0, 0, 0, 0, 0, 0);
        cyc(1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 1, 32'h100, 0, 0);
        cyc(1, 1, 1, 0, 0, 0, 0, 0, 1, 0, 1, 32'h101, 0, 0);
        cyc(1, 1, 2, 0, 0, 0, 0, 0, 1, 0, 1, 32'h102, 0, 0);
        cyc(1, 0, 0, 0, 1, 1, 5, 32'hDEADBEEF, 0, 1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 1, 0, 5, 0, 0, 1, 0, 0, 1, 32'hDEADBEEF);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 12; k++) begin
            int ig;
            ig = (k % 5 == 4) ? 1 : 0;
            cyc(1, 1, 3, 0, 1, 0, 6, 0, ig, 1 - ig, ig, 32'h103, 1 - ig, 32'h106);
        end
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 1, 7, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        cyc(1, 1, 8, 1, 0, 0, 0, 0, 1, 0, 1, 32'h108, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 1, 3, 0, 1, 0, 9, 0, 0, 1, 0, 0, 1, 32'h109);
        cyc(1, 1, 3, 0, 1, 0, 9, 0, 0, 1, 0, 0, 1, 32'h109);
        cyc(1, 1, 3, 0, 1, 0, 9, 0, 0, 1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 5; k++) begin
            int ig;
            ig = (k == 4) ? 1 : 0;
            cyc(1, 1, 3, 0, 1, 0, 9, 0, ig, 1 - ig, ig, 32'h103, 1 - ig, 32'h109);
        end
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge w_clk);
        #1;
        checks++;
        if (q_i.size() != 0 || q_d.size() != 0) begin
            errs++;
            $display("FAIL drain got pending i=%0d d=%0d want 0 0", q_i.size(), q_d.size());
        end
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
